// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_if
//  Description : Bundle for the register-file write-back block. Carries the
//                ALU result port, the long-latency (LSU / mul / div) valid/
//                ready result port, the register-file write port and the
//                buffered-entry count.
//                  master : the write-back block (drives rw/dest/write_data,
//                           lsu_ready and pending_count)
//                  slave  : the core side (drives ALU and LSU results)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    // ALU result path: priority, no backpressure
    logic                     alu_valid;
    logic [4:0]               alu_dest;
    logic [XLEN-1:0]          alu_data;

    // Long-latency result path: valid/ready handshake
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [4:0]               lsu_dest;
    logic [XLEN-1:0]          lsu_data;

    // Register file write port
    logic                     rw;
    logic [4:0]               dest;
    logic [XLEN-1:0]          write_data;

    // Number of occupied FIFO slots (squashed entries included)
    logic [$clog2(DEPTH):0]   pending_count;

    modport master (
        input  alu_valid, alu_dest, alu_data,
        input  lsu_valid, lsu_dest, lsu_data,
        output lsu_ready,
        output rw, dest, write_data,
        output pending_count
    );

    modport slave (
        output alu_valid, alu_dest, alu_data,
        output lsu_valid, lsu_dest, lsu_data,
        input  lsu_ready,
        input  rw, dest, write_data,
        input  pending_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write-side master for the 32x32 integer register file.
//                Merges the single-cycle ALU result (priority, no
//                backpressure) with long-latency results that are buffered
//                in an in-order FIFO. Buffered results whose destination is
//                overwritten by a younger ALU result are squashed (kept in
//                their slot but never written).
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-low reset
//                bus  - regfile_writeback_if.master
//                       alu_valid/alu_dest/alu_data   ALU result in
//                       lsu_valid/lsu_ready/lsu_dest/lsu_data  LSU result in
//                       rw/dest/write_data             register file write
//                       pending_count                  occupied FIFO slots
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  wire                          clk,
    input  wire                          rst,
    regfile_writeback_if.master          bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [4:0]        w_ent_dest [DEPTH];
    logic [XLEN-1:0]   w_ent_data [DEPTH];
    logic              w_ent_vld  [DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_alu_sel;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_push_vld;
    logic              w_head_vld;
    logic [4:0]        w_head_dest;
    logic [XLEN-1:0]   w_head_data;

    assign w_full    = (r_count == c_full_count);
    assign w_empty   = (r_count == '0);

    // x0 is never written, so an ALU result for x0 loses arbitration
    assign w_alu_sel = bus.alu_valid && (bus.alu_dest != 5'd0);

    // Ready is a function of registered occupancy only
    assign bus.lsu_ready = !w_full;

    // Accepted results for x0 are consumed by the handshake but not stored
    assign w_accept  = bus.lsu_valid && !w_full;
    assign w_push    = w_accept && (bus.lsu_dest != 5'd0);

    // The ALU owns the output register whenever it is selected
    assign w_pop     = !w_alu_sel && !w_empty;

    // A result arriving alongside a same-destination ALU write is older
    // than that write, so it is stored already squashed
    assign w_push_vld = !(w_alu_sel && (bus.lsu_dest == bus.alu_dest));

    assign w_head_vld  = w_ent_vld[r_rd_ptr];
    assign w_head_dest = w_ent_dest[r_rd_ptr];
    assign w_head_data = w_ent_data[r_rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage, one register set per slot
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [4:0]      r_dest;
        logic [XLEN-1:0] r_data;
        logic            r_vld;
        logic            w_wr_here;
        logic            w_rd_here;
        logic            w_squash;

        assign w_wr_here = w_push && (r_wr_ptr == PTR_W'(gi));
        assign w_rd_here = w_pop  && (r_rd_ptr == PTR_W'(gi));
        assign w_squash  = w_alu_sel && (r_dest == bus.alu_dest);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dest <= 5'd0;
                r_data <= '0;
                r_vld  <= 1'b0;
            end else if (w_wr_here) begin
                r_dest <= bus.lsu_dest;
                r_data <= bus.lsu_data;
                r_vld  <= w_push_vld;
            end else if (w_rd_here || w_squash) begin
                // Popped slots are cleared so free slots never look live
                r_vld  <= 1'b0;
            end
        end

        assign w_ent_dest[gi] = r_dest;
        assign w_ent_data[gi] = r_data;
        assign w_ent_vld[gi]  = r_vld;
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.pending_count = r_count;

    // ------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------
    logic              r_rw;
    logic [4:0]        r_dest_o;
    logic [XLEN-1:0]   r_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rw     <= 1'b0;
            r_dest_o <= 5'd0;
            r_wdata  <= '0;
        end else if (w_alu_sel) begin
            r_rw     <= 1'b1;
            r_dest_o <= bus.alu_dest;
            r_wdata  <= bus.alu_data;
        end else if (w_pop && w_head_vld) begin
            r_rw     <= 1'b1;
            r_dest_o <= w_head_dest;
            r_wdata  <= w_head_data;
        end else begin
            // Squashed pop or idle: no write, index/data hold
            r_rw     <= 1'b0;
        end
    end

    assign bus.rw         = r_rw;
    assign bus.dest       = r_dest_o;
    assign bus.write_data = r_wdata;

endmodule
`default_nettype wire
